dpram_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the 1Kx16 internal DPRAM port (A, DIn, RD, WR, DOut, Done).

---
 rtl/dpram_port_arbiter_if.sv | 44 ++++
 rtl/dpram_port_arbiter.sv | 100 ++++++++++
 tb/tb_dpram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for the two-port DPRAM arbiter.
// master = requesters plus RAM data return; slave = the arbiter itself.
interface dpram_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;

  logic [DW-1:0] rdata;

  logic [AW-1:0] A;
  logic [DW-1:0] DIn;
  logic          RD;
  logic          WR;
  logic [DW-1:0] DOut;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output DOut,
    input  gnt0, done0, gnt1, done1, rdata,
    input  A, DIn, RD, WR
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  DOut,
    output gnt0, done0, gnt1, done1, rdata,
    output A, DIn, RD, WR
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin sequencer for one DPRAM port: grant +1, strobe HOLD_CYCLES, done +HOLD_CYCLES+2.
// Requests are levels sampled only while idle; a losing requester just holds req until granted.
module dpram_port_arbiter #(
  parameter int AW          = 10,
  parameter int DW          = 16,
  parameter int HOLD_CYCLES = 7
) (
  input logic                 clk,
  input logic                 ar,
  dpram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FINISH} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t        state;
  logic [3:0]    hold_cnt;
  logic          last_gnt;
  logic          op_wr;

  logic          win1;
  logic          we_win;
  logic [AW-1:0] addr_win;
  logic [DW-1:0] wdata_win;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    win1 = bus.req1;
    if (bus.req0 && bus.req1) begin
      win1 = ~last_gnt;
    end
    we_win    = win1 ? bus.we1    : bus.we0;
    addr_win  = win1 ? bus.addr1  : bus.addr0;
    wdata_win = win1 ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_gnt  <= 1'b1;
      op_wr     <= 1'b0;
      bus.A     <= '0;
      bus.DIn   <= '0;
      bus.RD    <= 1'b0;
      bus.WR    <= 1'b0;
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state    <= SETUP;
            last_gnt <= win1;
            bus.gnt0 <= ~win1;
            bus.gnt1 <= win1;
            op_wr    <= we_win;
            bus.A    <= addr_win;
            bus.DIn  <= wdata_win;
          end
        end
        SETUP: begin
          hold_cnt <= '0;
          bus.RD   <= ~op_wr;
          bus.WR   <= op_wr;
          state    <= ACCESS;
        end
        ACCESS: begin
          hold_cnt <= hold_cnt + 4'd1;
          if (hold_cnt == HOLD_LAST) begin
            // Strobes drop, read data is captured and done fires on the same edge.
            state     <= FINISH;
            bus.RD    <= 1'b0;
            bus.WR    <= 1'b0;
            bus.done0 <= bus.gnt0;
            bus.done1 <= bus.gnt1;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            if (!op_wr) begin
              bus.rdata <= bus.DOut;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench: randomized two-requester traffic against a cycle-phase reference model, plus directed
// reset-abort, contention-order, full-sweep and single-cycle-hold scenarios.
module tb_dpram_port_arbiter;

  localparam int H = 7;

  logic clk = 1'b0;
  logic ar;
  always #5 clk = ~clk;

  dpram_port_arbiter_if #(.AW(10), .DW(16)) u_if ();
  dpram_port_arbiter_if #(.AW(10), .DW(16)) u_if1 ();

  dpram_port_arbiter #(.AW(10), .DW(16), .HOLD_CYCLES(H)) u_dut (
    .clk (clk),
    .ar  (ar),
    .bus (u_if)
  );

  dpram_port_arbiter #(.AW(10), .DW(16), .HOLD_CYCLES(1)) u_dut1 (
    .clk (clk),
    .ar  (ar),
    .bus (u_if1)
  );

  // RAM behind the main arbiter; the short-hold instance reads a fixed address pattern.
  logic [15:0] ram [1024];
  always @(posedge clk) if (u_if.WR) ram[u_if.A] <= u_if.DIn;
  assign u_if.DOut  = ram[u_if.A];
  assign u_if1.DOut = {6'd0, u_if1.A} ^ 16'h1234;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: p = cycles since the grant edge (0 = idle).
  int          p;
  bit          cur, last, m_wr;
  logic [9:0]  m_a;
  logic [15:0] m_din, m_rdata;
  logic [15:0] ref_mem [1024];
  bit          s_done [2];
  bit          s_strobe;

  task automatic model_reset();
    p = 0; cur = 0; last = 1; m_wr = 0; m_a = '0; m_din = '0; m_rdata = '0;
  endtask

  task automatic drive(input int r, input bit rq, input bit we, input logic [9:0] a, input logic [15:0] d);
    if (r == 0) begin
      u_if.req0 = rq; u_if.we0 = we; u_if.addr0 = a; u_if.wdata0 = d;
    end else begin
      u_if.req1 = rq; u_if.we1 = we; u_if.addr1 = a; u_if.wdata1 = d;
    end
  endtask

  function automatic bit req_of(input int r);
    return (r == 0) ? u_if.req0 : u_if.req1;
  endfunction

  // One clock: check this cycle's outputs at negedge, advance the model at posedge, return #1 later.
  task automatic step();
    bit w;
    @(negedge clk);
    chk("gnt0",  u_if.gnt0,  p >= 1 && p <= H + 1 && cur == 1'b0);
    chk("gnt1",  u_if.gnt1,  p >= 1 && p <= H + 1 && cur == 1'b1);
    chk("rd",    u_if.RD,    p >= 2 && p <= H + 1 && !m_wr);
    chk("wr",    u_if.WR,    p >= 2 && p <= H + 1 && m_wr);
    chk("done0", u_if.done0, p == H + 2 && cur == 1'b0);
    chk("done1", u_if.done1, p == H + 2 && cur == 1'b1);
    chk("addr",  u_if.A,     m_a);
    chk("din",   u_if.DIn,   m_din);
    chk("rdata", u_if.rdata, m_rdata);
    s_done[0] = u_if.done0;
    s_done[1] = u_if.done1;
    s_strobe  = u_if.RD | u_if.WR;
    @(posedge clk);
    if (p == 0) begin
      if (u_if.req0 || u_if.req1) begin
        w     = (u_if.req0 && u_if.req1) ? !last : u_if.req1;
        cur   = w;
        last  = w;
        m_wr  = w ? u_if.we1    : u_if.we0;
        m_a   = w ? u_if.addr1  : u_if.addr0;
        m_din = w ? u_if.wdata1 : u_if.wdata0;
        p     = 1;
      end
    end else if (p == H + 2) begin
      p = 0;
    end else begin
      if (p == H + 1) begin
        if (m_wr) ref_mem[m_a] = m_din;
        else      m_rdata = ref_mem[m_a];
      end
      p++;
    end
    #1;
  endtask

  // Single access on requester r from idle; lat = cycles from the request cycle to done.
  task automatic run_access(input int r, input bit we, input logic [9:0] a, input logic [15:0] d,
                            output int lat, output int strobes);
    lat = -1;
    strobes = 0;
    drive(r, 1, we, a, d);
    for (int n = 0; n < 40; n++) begin
      step();
      strobes += int'(s_strobe);
      if (n == 0) drive(r, 0, 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom));
      if (s_done[r]) begin
        lat = n;
        break;
      end
    end
    chk("access_timeout", lat >= 0, 1);
  endtask

  task automatic h1_access(input bit we, input logic [9:0] a, output int lat, output int width);
    lat = -1;
    width = 0;
    u_if1.we0 = we; u_if1.addr0 = a; u_if1.wdata0 = 16'hA5A5; u_if1.req0 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      width += int'(u_if1.RD | u_if1.WR);
      chk("h1_excl", u_if1.RD & u_if1.WR, 0);
      if (u_if1.done0) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
      u_if1.req0 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int lat, st, order[$], dcyc[$], cyc;
    bit exp_order [4];

    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    u_if1.req0 = 0; u_if1.we0 = 0; u_if1.addr0 = '0; u_if1.wdata0 = '0;
    u_if1.req1 = 0; u_if1.we1 = 0; u_if1.addr1 = '0; u_if1.wdata1 = '0;
    model_reset();
    ar = 1'b0;
    step();
    step();
    ar = 1'b1;

    // Reset while WR is high: strobe and grant fall at once, no done afterwards.
    drive(0, 1, 1, 10'h200, 16'hBEEF);
    step();
    step();
    step();
    chk("pre_abort_wr", u_if.WR, 1);
    #2;
    ar = 1'b0;
    #1;
    chk("abort_wr",   u_if.WR,   0);
    chk("abort_gnt0", u_if.gnt0, 0);
    chk("abort_gnt1", u_if.gnt1, 0);
    drive(0, 0, 0, '0, '0);
    model_reset();
    step();
    step();
    ar = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Write then read back through requester 0.
    run_access(0, 1, 10'h005, 16'h004B, lat, st);
    chk("wr_done_lat", lat, 9);
    chk("wr_width",    st,  7);
    run_access(0, 0, 10'h005, 16'h0000, lat, st);
    chk("rd_done_lat", lat, 9);
    chk("rd_data",     u_if.rdata, 16'h004B);

    // Both requesting from reset: strict alternation starting with requester 0.
    drive(0, 0, 0, '0, '0);
    model_reset();
    ar = 1'b0;
    step();
    ar = 1'b1;
    drive(0, 1, 0, 10'h005, 16'h1111);
    drive(1, 1, 0, 10'h006, 16'h2222);
    cyc = 0;
    while (order.size() < 4 && cyc < 80) begin
      step();
      if (s_done[0]) begin order.push_back(0); dcyc.push_back(cyc); end
      if (s_done[1]) begin order.push_back(1); dcyc.push_back(cyc); end
      cyc++;
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    chk("tie_count", order.size(), 4);
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < order.size() && i < 4; i++) begin
      chk("tie_order", order[i], exp_order[i]);
      if (i > 0) chk("tie_spacing", dcyc[i] - dcyc[i-1], H + 3);
    end
    step();

    // Requester 1 holds req; requester 0 arrives mid-access and is served next.
    order.delete();
    drive(1, 1, 0, 10'h007, 16'h0);
    cyc = 0;
    while (order.size() < 3 && cyc < 80) begin
      step();
      if (cyc == 3) drive(0, 1, 1, 10'h008, 16'h3333);
      if (s_done[0]) order.push_back(0);
      if (s_done[1]) order.push_back(1);
      cyc++;
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    chk("late_count", order.size(), 3);
    exp_order = '{1, 0, 1, 0};
    for (int i = 0; i < order.size() && i < 3; i++) chk("late_order", order[i], exp_order[i]);
    for (int i = 0; i < 12; i++) step();

    // Random traffic: requesters hold until done, sometimes re-request back-to-back.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        if (!req_of(r)) begin
          if ($urandom_range(0, 3) == 0)
            drive(r, 1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
        end else if (p == H + 2 && cur == 1'(r)) begin
          if ($urandom_range(0, 1) == 0) drive(r, 0, 0, '0, '0);
          else drive(r, 1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
        end else if (p >= 1 && p <= H + 1 && cur == 1'(r) && $urandom_range(0, 1) == 0) begin
          drive(r, 1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 16'($urandom));
        end
      end
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    for (int i = 0; i < 14; i++) step();

    // Self-test sweep through requester 1.
    for (int a = 0; a < 1024; a++) run_access(1, 1, 10'(a), 16'(a * 15), lat, st);
    for (int a = 0; a < 1024; a++) begin
      run_access(1, 0, 10'(a), 16'($urandom), lat, st);
      chk("sweep_rdata", u_if.rdata, 16'(a * 15));
    end
    chk("sweep_3ff", u_if.rdata, 16'h3BF1);

    // Single-cycle hold instance.
    h1_access(0, 10'h0AB, lat, st);
    chk("h1_rd_lat",   lat, 3);
    chk("h1_rd_width", st,  1);
    chk("h1_rdata",    u_if1.rdata, 16'h00AB ^ 16'h1234);
    h1_access(1, 10'h155, lat, st);
    chk("h1_wr_lat",   lat, 3);
    chk("h1_wr_width", st,  1);
    chk("h1_wr_addr",  u_if1.A, 10'h155);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
